generador_direccion: RTL

GENERADOR_DIRECCION -- requirements
Module: generador_direccion

---
 rtl/generador_direccion.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/generador_direccion.sv
// Raster-to-frame-buffer read address generator with 1x/2x/4x pixel replication.
// Optional double buffering is enabled by defining GENERADOR_DIRECCION_DOUBLE_BUFFER_EN.
module generador_direccion #(
  parameter int ADDR_W = 18,
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int WIN_W  = 400,
  parameter int WIN_H  = 400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [1:0]        mode,
`ifdef GENERADOR_DIRECCION_DOUBLE_BUFFER_EN
  input  logic              swap_req,
  output logic              bank,
  output logic              swap_ack,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              frame_start
);

  localparam logic [10:0] X_LO = 11'(WIN_X0);
  localparam logic [10:0] X_HI = 11'(WIN_X0 + WIN_W - 1);
  localparam logic [10:0] Y_LO = 11'(WIN_Y0);
  localparam logic [10:0] Y_HI = 11'(WIN_Y0 + WIN_H - 1);
  localparam logic [ADDR_W-1:0] WIN_W_A = ADDR_W'(WIN_W);

  logic [ADDR_W-1:0] row_base_reg, row_base_next;
  logic [ADDR_W-1:0] col_reg, col_next;
  logic [1:0]        sub_x_reg, sub_x_next;
  logic [1:0]        sub_y_reg, sub_y_next;
  logic [1:0]        mode_reg, mode_next;
  logic              armed_reg, armed_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              valid_reg, valid_next;
  logic              frame_start_reg, frame_start_next;

  logic              at_origin, in_win, last_col, armed_use;
  logic [1:0]        mode_use, rep_max;
  logic [ADDR_W-1:0] src_w, bank_ofs;
  logic [ADDR_W-1:0] cur_row, cur_col;
  logic [1:0]        cur_sx, cur_sy;

  assign at_origin = (x == 10'd0) && (y == 10'd0);
  assign in_win    = ({1'b0, x} >= X_LO) && ({1'b0, x} <= X_HI) &&
                     ({1'b0, y} >= Y_LO) && ({1'b0, y} <= Y_HI);
  assign last_col  = ({1'b0, x} == X_HI);

  // The origin pixel sees a freshly cleared state and the newly latched mode.
  assign mode_use  = at_origin ? mode : mode_reg;
  assign armed_use = at_origin | armed_reg;
  assign cur_row   = at_origin ? '0 : row_base_reg;
  assign cur_col   = at_origin ? '0 : col_reg;
  assign cur_sx    = at_origin ? 2'd0 : sub_x_reg;
  assign cur_sy    = at_origin ? 2'd0 : sub_y_reg;

  always_comb begin
    case (mode_use)
      2'b01: begin rep_max = 2'd1; src_w = WIN_W_A >> 1; end
      2'b10: begin rep_max = 2'd3; src_w = WIN_W_A >> 2; end
      default: begin rep_max = 2'd0; src_w = WIN_W_A; end
    endcase
  end

`ifdef GENERADOR_DIRECCION_DOUBLE_BUFFER_EN
  localparam logic [ADDR_W-1:0] BANK_OFS = ADDR_W'(WIN_W * WIN_H);
  logic bank_reg, bank_next, swap_ack_reg, swap_ack_next;

  assign swap_ack_next = at_origin & swap_req;
  assign bank_next     = bank_reg ^ swap_ack_next;
  assign bank_ofs      = bank_next ? BANK_OFS : '0;
  assign bank          = bank_reg;
  assign swap_ack      = swap_ack_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_reg     <= 1'b0;
      swap_ack_reg <= 1'b0;
    end else begin
      bank_reg     <= bank_next;
      swap_ack_reg <= swap_ack_next;
    end
  end
`else
  assign bank_ofs = '0;
`endif

  always_comb begin
    row_base_next    = cur_row;
    col_next         = cur_col;
    sub_x_next       = cur_sx;
    sub_y_next       = cur_sy;
    mode_next        = mode_use;
    armed_next       = armed_use;
    addr_next        = addr_reg;
    valid_next       = 1'b0;
    frame_start_next = at_origin;
    if (armed_use && in_win) begin
      addr_next  = cur_row + cur_col + bank_ofs;
      valid_next = 1'b1;
      if (last_col) begin
        col_next   = '0;
        sub_x_next = 2'd0;
        if (cur_sy == rep_max) begin
          sub_y_next    = 2'd0;
          row_base_next = cur_row + src_w;
        end else begin
          sub_y_next = cur_sy + 2'd1;
        end
      end else if (cur_sx == rep_max) begin
        sub_x_next = 2'd0;
        col_next   = cur_col + ADDR_W'(1);
      end else begin
        sub_x_next = cur_sx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_reg    <= '0;
      col_reg         <= '0;
      sub_x_reg       <= 2'd0;
      sub_y_reg       <= 2'd0;
      mode_reg        <= 2'b00;
      armed_reg       <= 1'b0;
      addr_reg        <= '0;
      valid_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      row_base_reg    <= row_base_next;
      col_reg         <= col_next;
      sub_x_reg       <= sub_x_next;
      sub_y_reg       <= sub_y_next;
      mode_reg        <= mode_next;
      armed_reg       <= armed_next;
      addr_reg        <= addr_next;
      valid_reg       <= valid_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign addr        = addr_reg;
  assign valid       = valid_reg;
  assign frame_start = frame_start_reg;

endmodule
